// File: rtl/clk_div_gen_if.sv
// Control/status bundle for clk_div_gen: run request, divisor load, divided clock and status.
interface clk_div_gen_if #(
  parameter int unsigned CNT_W = 8
);
  logic             EN;
  logic [CNT_W-1:0] DIV_IN;
  logic             DIV_LD;
  logic             CLKOUT;
  logic             CE_PULSE;
  logic [CNT_W-1:0] DIV_OUT;
  logic             DIV_ACK;
  logic             DIV_ERR;
  logic             BUSY;

  modport master (
    output EN, DIV_IN, DIV_LD,
    input  CLKOUT, CE_PULSE, DIV_OUT, DIV_ACK, DIV_ERR, BUSY
  );

  modport slave (
    input  EN, DIV_IN, DIV_LD,
    output CLKOUT, CE_PULSE, DIV_OUT, DIV_ACK, DIV_ERR, BUSY
  );
endinterface

// File: rtl/clk_div_gen.sv
// Runtime-programmable integer clock divider with double-buffered divisor and
// glitch-free start/stop; every output is registered.
module clk_div_gen #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input logic           CLKIN,
  input logic           SCLR,
  clk_div_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] d;
  logic [CNT_W-1:0] pend_val;
  logic             pend;
  logic             clkout;
  logic             ce;
  logic             ack;
  logic             err;
  logic             busy;

  logic [CNT_W:0]   half;
  logic [CNT_W-1:0] cnt_inc;
  logic             wrap;
  logic             ld_ok;
  logic             ld_bad;
  logic             high_inc;

  always_comb begin
    half     = ({1'b0, d} + 1'b1) >> 1;
    cnt_inc  = cnt + 1'b1;
    wrap     = (cnt == d - 1'b1);
    ld_ok    = bus.DIV_LD && (bus.DIV_IN >= CNT_W'(2));
    ld_bad   = bus.DIV_LD && (bus.DIV_IN <  CNT_W'(2));
    high_inc = ({1'b0, cnt_inc} < half);
  end

  always_ff @(posedge CLKIN) begin
    if (SCLR) begin
      state    <= IDLE;
      cnt      <= '0;
      d        <= CNT_W'(DEFAULT_DIV);
      pend_val <= '0;
      pend     <= 1'b0;
      clkout   <= 1'b0;
      ce       <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      err <= ld_bad;
      ack <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (ld_ok) begin
            d    <= bus.DIV_IN;
            ack  <= 1'b1;
            pend <= 1'b0;
          end
          if (bus.EN) begin
            state  <= RUN;
            clkout <= 1'b1;
            ce     <= 1'b1;
            busy   <= 1'b1;
          end else begin
            clkout <= 1'b0;
            ce     <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: begin
          if (ld_ok) begin
            pend_val <= bus.DIV_IN;
            pend     <= 1'b1;
          end
          if (wrap) begin
            // Old pend_val is applied here; a same-cycle load stays pending.
            cnt <= '0;
            if (pend) begin
              d   <= pend_val;
              ack <= 1'b1;
              if (!ld_ok) pend <= 1'b0;
            end
            if (bus.EN) begin
              state  <= RUN;
              clkout <= 1'b1;
              ce     <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state  <= IDLE;
              clkout <= 1'b0;
              ce     <= 1'b0;
              busy   <= 1'b0;
            end
          end else begin
            cnt    <= cnt_inc;
            clkout <= high_inc;
            ce     <= 1'b0;
            busy   <= 1'b1;
            if (!bus.EN) state <= DRAIN;
          end
        end
      endcase
    end
  end

  assign bus.CLKOUT   = clkout;
  assign bus.CE_PULSE = ce;
  assign bus.DIV_OUT  = d;
  assign bus.DIV_ACK  = ack;
  assign bus.DIV_ERR  = err;
  assign bus.BUSY     = busy;
endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: a period-pattern model checked every cycle
// plus literal expectations taken from the intended waveforms.
module tb_clk_div_gen;
  logic clk = 1'b0;
  logic sclr;
  int unsigned total = 0;
  int unsigned bad   = 0;

  clk_div_gen_if #(.CNT_W(8)) bus ();

  clk_div_gen #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
    .CLKIN(clk),
    .SCLR (sclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each period is a queue of CLKOUT levels built from the divisor;
  // the next period (or idle) is decided from EN when the queue runs dry.
  bit          per[$];
  bit          running = 0;
  int unsigned m_d = 4, pval = 0;
  bit          pend = 0;
  bit          e_clk = 0, e_ce = 0, e_ack = 0, e_err = 0, e_busy = 0;

  function automatic void start_period();
    per.delete();
    for (int unsigned i = 0; i < m_d; i++) per.push_back(i < (m_d + 1) / 2);
    e_clk   = per.pop_front();
    e_ce    = 1;
    e_busy  = 1;
    running = 1;
  endfunction

  function automatic void go_idle();
    per.delete();
    running = 0;
    e_clk   = 0;
    e_ce    = 0;
    e_busy  = 0;
  endfunction

  always @(posedge clk) begin
    bit ok;
    if (sclr) begin
      m_d = 4; pend = 0; e_ack = 0; e_err = 0;
      go_idle();
    end else begin
      ok    = bus.DIV_LD && (bus.DIV_IN >= 2);
      e_err = bus.DIV_LD && (bus.DIV_IN < 2);
      e_ack = 0;
      if (!running) begin
        if (ok) begin m_d = bus.DIV_IN; e_ack = 1; pend = 0; end
        if (bus.EN) start_period(); else go_idle();
      end else if (per.size() == 0) begin
        if (pend) begin m_d = pval; e_ack = 1; pend = 0; end
        if (ok) begin pval = bus.DIV_IN; pend = 1; end
        if (bus.EN) start_period(); else go_idle();
      end else begin
        if (ok) begin pval = bus.DIV_IN; pend = 1; end
        e_clk = per.pop_front();
        e_ce  = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("clkout",   bus.CLKOUT,   e_clk);
    chk("ce_pulse", bus.CE_PULSE, e_ce);
    chk("div_ack",  bus.DIV_ACK,  e_ack);
    chk("div_err",  bus.DIV_ERR,  e_err);
    chk("busy",     bus.BUSY,     e_busy);
    chk("div_out",  bus.DIV_OUT,  m_d);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input int unsigned lim);
    int unsigned n = 0;
    while (!bus.DIV_ACK && n < lim) begin tick(); n++; end
    chk("ack_within_bound", bus.DIV_ACK, 1);
  endtask

  task automatic wait_idle(input int unsigned lim);
    int unsigned n = 0;
    while (bus.BUSY && n < lim) begin tick(); n++; end
    chk("idle_within_bound", bus.BUSY, 0);
  endtask

  initial begin
    logic [7:0] pat4;
    logic [9:0] pat5;
    pat4 = 8'b1100_1100;
    pat5 = 10'b11100_11100;
    sclr = 1; bus.EN = 0; bus.DIV_IN = '0; bus.DIV_LD = 0;
    ticks(3);
    chk("rst_clkout", bus.CLKOUT, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_div_out", bus.DIV_OUT, 4);
    sclr = 0;

    // default divide-by-4
    bus.EN = 1;
    tick();
    chk("first_ce", bus.CE_PULSE, 1);
    for (int i = 0; i < 8; i++) begin
      chk("pat_div4", bus.CLKOUT, pat4[7-i]);
      tick();
    end

    // odd divisor loaded while idle
    bus.EN = 0;
    wait_idle(10);
    bus.DIV_IN = 8'd5; bus.DIV_LD = 1;
    tick();
    chk("idle_ack", bus.DIV_ACK, 1);
    chk("idle_div5", bus.DIV_OUT, 5);
    bus.DIV_LD = 0; bus.EN = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("pat_div5", bus.CLKOUT, pat5[9-i]);
      tick();
    end

    // mid-period change 4 -> 6, then a load on a wrap cycle
    sclr = 1; bus.EN = 0;
    tick();
    sclr = 0; bus.EN = 1;
    tick();
    tick();
    bus.DIV_IN = 8'd6; bus.DIV_LD = 1;
    tick();
    bus.DIV_LD = 0;
    ticks(2);
    chk("mid_ack", bus.DIV_ACK, 1);
    chk("mid_ce", bus.CE_PULSE, 1);
    chk("mid_div6", bus.DIV_OUT, 6);
    ticks(5);
    bus.DIV_IN = 8'd8; bus.DIV_LD = 1;
    tick();
    bus.DIV_LD = 0;
    chk("wrap_load_no_ack", bus.DIV_ACK, 0);
    chk("wrap_load_still6", bus.DIV_OUT, 6);
    ticks(6);
    chk("wrap_load_ack", bus.DIV_ACK, 1);
    chk("wrap_load_div8", bus.DIV_OUT, 8);
    ticks(2);
    bus.DIV_IN = 8'd3; bus.DIV_LD = 1;
    tick();
    bus.DIV_LD = 0;
    ticks(4);
    bus.DIV_IN = 8'd5; bus.DIV_LD = 1;
    tick();
    bus.DIV_LD = 0;
    chk("older_pend_div3", bus.DIV_OUT, 3);
    ticks(3);
    chk("newer_pend_ack", bus.DIV_ACK, 1);
    chk("newer_pend_div5", bus.DIV_OUT, 5);

    // invalid loads
    bus.DIV_IN = 8'd1; bus.DIV_LD = 1;
    tick();
    chk("err_div1", bus.DIV_ERR, 1);
    bus.DIV_IN = 8'd0;
    tick();
    chk("err_div0", bus.DIV_ERR, 1);
    chk("err_keeps_div", bus.DIV_OUT, 5);
    bus.DIV_LD = 0;
    tick();
    chk("err_clears", bus.DIV_ERR, 0);

    // graceful stop with d = 6, then resume during drain
    bus.DIV_IN = 8'd6; bus.DIV_LD = 1;
    tick();
    bus.DIV_LD = 0;
    wait_ack(12);
    tick();
    bus.EN = 0;
    ticks(4);
    chk("drain_busy", bus.BUSY, 1);
    tick();
    chk("stop_busy", bus.BUSY, 0);
    chk("stop_clk", bus.CLKOUT, 0);
    bus.EN = 1;
    tick();
    tick();
    bus.EN = 0;
    tick();
    bus.EN = 1;
    ticks(4);
    chk("resume_ce", bus.CE_PULSE, 1);
    chk("resume_busy", bus.BUSY, 1);

    // reset mid-run discards a pending load
    bus.DIV_IN = 8'd10; bus.DIV_LD = 1;
    tick();
    bus.DIV_LD = 0;
    wait_ack(12);
    tick();
    bus.DIV_IN = 8'd3; bus.DIV_LD = 1;
    tick();
    bus.DIV_LD = 0;
    ticks(2);
    sclr = 1;
    tick();
    chk("sclr_clk", bus.CLKOUT, 0);
    chk("sclr_busy", bus.BUSY, 0);
    chk("sclr_div", bus.DIV_OUT, 4);
    sclr = 0;
    ticks(14);
    chk("pend_discarded", bus.DIV_OUT, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
